// File: rtl/hack_io_pkg.sv
// Hack SoC I/O map shared by the data-bus peripherals, plus the UART TX
// state encoding and the STAT register bit layout.
package hack_io_pkg;

  // Data-memory map (15-bit Hack data addresses)
  localparam logic [14:0] MEM_RAM_LAST  = 15'h3FFF;
  localparam logic [14:0] MEM_SW        = 15'h6001;
  localparam logic [14:0] MEM_KEYS      = 15'h6002;
  localparam logic [14:0] MEM_LEDG      = 15'h6003;
  localparam logic [14:0] MEM_UART_DATA = 15'h6004;
  localparam logic [14:0] MEM_UART_STAT = 15'h6005;

  // UART transmitter states; TX_PARITY is only visited in the parity build
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // STAT word bit positions
  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_PAR       = 3;
  localparam int STAT_COUNT_LSB = 8;

  // Assemble the STAT read word from its fields
  function automatic logic [15:0] stat_word(input logic [7:0] count, input logic par,
                                            input logic ovf, input logic full,
                                            input logic busy);
    logic [15:0] w;
    w                            = '0;
    w[STAT_COUNT_LSB +: 8]       = count;
    w[STAT_PAR]                  = par;
    w[STAT_OVF]                  = ovf;
    w[STAT_FULL]                 = full;
    w[STAT_BUSY]                 = busy;
    return w;
  endfunction

endpackage

// File: rtl/hack_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push while full is accepted
// when a pop happens on the same edge; otherwise it is dropped and the
// caller is expected to flag the overflow. Pop is only legal when non-empty.
module hack_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk_mem,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign o_full  = (o_count == CW'(DEPTH));
  assign o_empty = (o_count == '0);
  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);
  assign o_rdata = mem[rd_ptr];

  // Storage array: contents need no reset, pointers define validity
  always_ff @(posedge i_clk_mem) begin
    if (push_ok) mem[wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally modulo the power-of-two depth
  always_ff @(posedge i_clk_mem or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

endmodule

// File: rtl/hack_uart_tx.sv
// Memory-mapped UART transmitter on the Hack data bus.
// DATA (0x6004) write queues a byte; STAT (0x6005) reads
// {count, 0, parity_present, ovf, full, busy}, and a write to it clears ovf.
// Build option: define HACK_UART_PARITY_EN for an even-parity bit between
// the data bits and the stop bit (8E1); otherwise frames are 8N1.
module hack_uart_tx
  import hack_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        i_clk_mem,
  input  logic        i_reset,
  input  logic        i_cpu_ce,
  input  logic [14:0] i_addressM,
  input  logic [15:0] i_outM,
  input  logic        i_writeM,
  output logic        o_sel,
  output logic [15:0] o_rdata,
  output logic        o_txd,
  output logic        o_busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
`ifdef HACK_UART_PARITY_EN
  localparam logic PAR_PRESENT = 1'b1;
`else
  localparam logic PAR_PRESENT = 1'b0;
`endif

  tx_state_e     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          ovf;

  logic          sel_data, sel_stat, commit, push, clr_ovf, pop, baud_done;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    count8;
  logic          unused_hi_data;

  // Bus decode: one commit per CPU cycle, no matter how long writeM is held
  assign sel_data       = (i_addressM == MEM_UART_DATA);
  assign sel_stat       = (i_addressM == MEM_UART_STAT);
  assign commit         = i_cpu_ce & i_writeM;
  assign push           = commit & sel_data;
  assign clr_ovf        = commit & sel_stat;
  assign unused_hi_data = ^i_outM[15:8];

  assign baud_done = (baud_cnt == '0);
  // The FIFO is drained from IDLE, or straight out of an expiring STOP so
  // back-to-back frames have no idle bit between them
  assign pop = !fifo_empty &&
               ((state == TX_IDLE) || ((state == TX_STOP) && baud_done));

  hack_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk_mem (i_clk_mem),
    .i_reset   (i_reset),
    .i_push    (push),
    .i_wdata   (i_outM[7:0]),
    .i_pop     (pop),
    .o_rdata   (fifo_rdata),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (fifo_count)
  );

  // Zero-extend occupancy into the 8-bit STAT count field
  always_comb begin
    count8            = '0;
    count8[CW-1:0]    = fifo_count;
  end

  assign o_busy  = (state != TX_IDLE) || !fifo_empty;
  assign o_sel   = sel_data | sel_stat;
  assign o_rdata = sel_stat ? stat_word(count8, PAR_PRESENT, ovf, fifo_full, o_busy)
                            : 16'h0000;

  // Sticky overflow: a dropped push sets it, a STAT write clears it
  always_ff @(posedge i_clk_mem or posedge i_reset) begin
    if (i_reset)                             ovf <= 1'b0;
    else if (clr_ovf)                        ovf <= 1'b0;
    else if (push && fifo_full && !pop)      ovf <= 1'b1;
  end

  // TX FSM with baud down-counter; o_txd is registered
  always_ff @(posedge i_clk_mem or posedge i_reset) begin
    if (i_reset) begin
      state    <= TX_IDLE;
      o_txd    <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            state    <= TX_START;
            o_txd    <= 1'b0;
            baud_cnt <= BAUD_LOAD;
            shreg    <= fifo_rdata;
            par_bit  <= ^fifo_rdata;
          end
        end
        TX_START: begin
          if (baud_done) begin
            state    <= TX_DATA;
            o_txd    <= shreg[0];
            shreg    <= shreg >> 1;
            bit_idx  <= '0;
            baud_cnt <= BAUD_LOAD;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
`ifdef HACK_UART_PARITY_EN
              state <= TX_PARITY;
              o_txd <= par_bit;
`else
              state <= TX_STOP;
              o_txd <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              o_txd   <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`ifdef HACK_UART_PARITY_EN
        TX_PARITY: begin
          if (baud_done) begin
            state    <= TX_STOP;
            o_txd    <= 1'b1;
            baud_cnt <= BAUD_LOAD;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (baud_done) begin
            if (!fifo_empty) begin
              state    <= TX_START;
              o_txd    <= 1'b0;
              baud_cnt <= BAUD_LOAD;
              shreg    <= fifo_rdata;
              par_bit  <= ^fifo_rdata;
            end else begin
              state    <= TX_IDLE;
              o_txd    <= 1'b1;
              baud_cnt <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state    <= TX_IDLE;
          o_txd    <= 1'b1;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_uart_tx.sv
// Bench for hack_uart_tx: a line monitor decodes every frame on o_txd and
// compares it against bytes queued when the bus write was driven.
module tb_hack_uart_tx;
  import hack_io_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef HACK_UART_PARITY_EN
  localparam int   NB  = 11;
  localparam logic PAR = 1'b1;
`else
  localparam int   NB  = 10;
  localparam logic PAR = 1'b0;
`endif
  localparam int FRAME = NB * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, writeM = 1'b0;
  logic [14:0] addr = 15'h0000;
  logic [15:0] outM = 16'h0000;
  logic        sel, txd, busy;
  logic [15:0] rdata;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  int frames_started = 0, frames_ok = 0;

  hack_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk_mem  (clk),
    .i_reset    (rst),
    .i_cpu_ce   (ce),
    .i_addressM (addr),
    .i_outM     (outM),
    .i_writeM   (writeM),
    .o_sel      (sel),
    .o_rdata    (rdata),
    .o_txd      (txd),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: sample mid-bit, check framing, pop the scoreboard
  initial begin : monitor
    logic [NB-1:0] bits;
    logic [7:0]    d, e;
    bit            ab;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && txd === 1'b0) begin
        frames_started++;
        start_q.push_back(cyc);
        ab   = 1'b0;
        bits = '0;
        for (int c = 0; c < FRAME; c++) begin
          if (rst !== 1'b0) ab = 1'b1;
          if (c % CPB == CPB / 2) bits[c / CPB] = txd;
          if (c < FRAME - 1) @(negedge clk);
        end
        if (!ab) begin
          d = bits[8:1];
          checks++;
          if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) begin
            errors++;
            $display("FAIL framing: start=%b stop=%b, required start=0 stop=1", bits[0], bits[NB-1]);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got byte %h, scoreboard empty", d);
          end else begin
            e = exp_q.pop_front();
            if (d !== e) begin
              errors++;
              $display("FAIL frame_data: got %h, required %h", d, e);
            end
          end
`ifdef HACK_UART_PARITY_EN
          checks++;
          if (bits[9] !== ^d) begin
            errors++;
            $display("FAIL parity_bit: got %b, required %b for %h", bits[9], ^d, d);
          end
`endif
          frames_ok++;
        end
      end
    end
  end

  task automatic bus_write(input logic [14:0] a, input logic [15:0] v, input int hold,
                           input bit exp_push);
    @(negedge clk);
    addr = a; outM = v; writeM = 1'b1; ce = 1'b1;
    if (exp_push) exp_q.push_back(v[7:0]);
    @(negedge clk);
    ce = 1'b0;
    repeat (hold - 1) @(negedge clk);
    writeM = 1'b0;
  endtask

  task automatic read_stat(output logic [15:0] v);
    @(negedge clk);
    addr = MEM_UART_STAT; writeM = 1'b0;
    #1 v = rdata;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_txd_low(input int max, input string tag);
    int n;
    n = 0;
    while (txd !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (txd !== 1'b0) begin
      errors++;
      $display("FAIL %s_start_timeout: txd=%b, required 0 within %0d cycles", tag, txd, max);
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: txd=%b busy=%b, required txd=1 busy=0", txd, busy);
    end
    rst = 1'b0;
    read_stat(v);
    checks++;
    if (v !== {12'h000, PAR, 3'b000} || sel !== 1'b1) begin
      errors++;
      $display("FAIL reset_stat: got %h sel=%b, required %h sel=1", v, sel, {12'h000, PAR, 3'b000});
    end
    addr = MEM_UART_DATA;
    #1;
    checks++;
    if (rdata !== 16'h0000 || sel !== 1'b1) begin
      errors++;
      $display("FAIL data_read: got %h sel=%b, required 0000 sel=1", rdata, sel);
    end
    addr = MEM_LEDG;
    #1;
    checks++;
    if (sel !== 1'b0) begin
      errors++;
      $display("FAIL other_sel: got %b, required 0", sel);
    end
  endtask

  task automatic test_other_addr();
    int fs;
    logic [15:0] v;
    fs = frames_started;
    bus_write(15'h6006, 16'h0041, 1, 1'b0);
    repeat (20) @(negedge clk);
    read_stat(v);
    checks++;
    if (frames_started != fs || v !== {12'h000, PAR, 3'b000}) begin
      errors++;
      $display("FAIL other_addr_write: frames %0d stat %h, required frames %0d stat %h",
               frames_started, v, fs, {12'h000, PAR, 3'b000});
    end
  endtask

  task automatic test_single();
    logic [NB-1:0] fv;
    logic [7:0]    d;
    int            mism;
    d = 8'h55;
    fv = '0;
    for (int i = 0; i < 8; i++) fv[i+1] = d[i];
`ifdef HACK_UART_PARITY_EN
    fv[9] = ^d;
`endif
    fv[NB-1] = 1'b1;
    @(negedge clk);
    addr = MEM_UART_DATA; outM = 16'h0055; writeM = 1'b1; ce = 1'b1;
    exp_q.push_back(d);
    @(negedge clk);
    ce = 1'b0; writeM = 1'b0;
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("FAIL latency_early: txd=%b one edge after push, required 1", txd);
    end
    @(negedge clk);
    mism = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (txd !== fv[c / CPB]) mism++;
      if (c < FRAME - 1) @(negedge clk);
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL waveform_55: %0d cycle mismatches, required 0", mism);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_stop: got %b, required 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL end_of_frame: busy=%b txd=%b, required busy=0 txd=1", busy, txd);
    end
  endtask

  task automatic test_held_write();
    int f0;
    f0 = frames_ok;
    bus_write(MEM_UART_DATA, 16'h00A3, 8, 1'b1);
    wait_idle(FRAME + 20, "held");
    repeat (FRAME) @(negedge clk);
    checks++;
    if (frames_ok - f0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL held_write: frames %0d queue %0d, required frames 1 queue 0",
               frames_ok - f0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int f0, s0, gaps;
    logic [15:0] v;
    f0 = frames_ok;
    s0 = start_q.size();
    bus_write(MEM_UART_DATA, 16'h0011, 1, 1'b1);
    wait_txd_low(10, "b2b");
    for (int i = 0; i < 6; i++) bus_write(MEM_UART_DATA, 16'h0021 + 16'(i), 1, i < DEPTH);
    read_stat(v);
    checks++;
    if (v !== {8'd4, 4'h0, PAR, 3'b111}) begin
      errors++;
      $display("FAIL stat_overflow: got %h, required %h", v, {8'd4, 4'h0, PAR, 3'b111});
    end
    bus_write(MEM_UART_STAT, 16'hFFFF, 1, 1'b0);
    read_stat(v);
    checks++;
    if (v !== {8'd4, 4'h0, PAR, 3'b011}) begin
      errors++;
      $display("FAIL ovf_clear: got %h, required %h", v, {8'd4, 4'h0, PAR, 3'b011});
    end
    wait_idle(5 * FRAME + 50, "b2b");
    checks++;
    if (frames_ok - f0 != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_frames: frames %0d queue %0d, required frames 5 queue 0",
               frames_ok - f0, exp_q.size());
    end
    gaps = 0;
    for (int i = 0; i < 4; i++)
      if (s0 + i + 1 < start_q.size() && start_q[s0+i+1] - start_q[s0+i] != FRAME) gaps++;
    checks++;
    if (gaps != 0 || start_q.size() - s0 != 5) begin
      errors++;
      $display("FAIL b2b_spacing: %0d bad gaps over %0d starts, required 0 over 5",
               gaps, start_q.size() - s0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int fs;
    bus_write(MEM_UART_DATA, 16'h005A, 1, 1'b0);
    bus_write(MEM_UART_DATA, 16'h00C3, 1, 1'b0);
    wait_txd_low(10, "rst");
    repeat (3 * CPB + 1) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    addr = MEM_UART_STAT; writeM = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("FAIL async_abort: txd=%b, required 1", txd);
    end
    checks++;
    if (rdata !== {12'h000, PAR, 3'b000}) begin
      errors++;
      $display("FAIL reset_count: stat %h, required %h", rdata, {12'h000, PAR, 3'b000});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fs = frames_started;
    repeat (FRAME + 20) @(negedge clk);
    checks++;
    if (frames_started != fs || txd !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL residual_frame: starts %0d txd=%b busy=%b, required starts %0d txd=1 busy=0",
               frames_started, txd, busy, fs);
    end
  endtask

  task automatic test_frame_len();
    int t0, n;
    bus_write(MEM_UART_DATA, 16'h0007, 1, 1'b1);
    wait_txd_low(10, "len");
    t0 = cyc;
    n = 0;
    while (busy !== 1'b0 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc - t0 != FRAME) begin
      errors++;
      $display("FAIL frame_length: %0d clk, required %0d", cyc - t0, FRAME);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_07_pending: queue %0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_other_addr();
    test_single();
    test_held_write();
    test_back_to_back();
    test_reset_mid_frame();
    test_frame_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
